// File: rtl/vx_commit_sender_pkg.sv
// Shared types and sizing for the commit sender slice.
// Commit packet layout matches the data carried by vx_commit_if.
package vx_commit_sender_pkg;

    localparam int NUM_THREADS   = 8;
    localparam int NUM_WARPS     = 4;
    localparam int NW_WIDTH      = 2;
    localparam int UUID_WIDTH    = 44;
    localparam int PC_BITS       = 30;
    localparam int NR_BITS       = 6;
    localparam int XLEN          = 32;
    localparam int PERF_CTR_BITS = 44;

    typedef struct packed {
        logic [UUID_WIDTH-1:0]             uuid;
        logic [NW_WIDTH-1:0]               wid;
        logic [NUM_THREADS-1:0]            tmask;
        logic [PC_BITS-1:0]                PC;
        logic                              wb;
        logic [NR_BITS-1:0]                rd;
        logic [NUM_THREADS-1:0][XLEN-1:0]  data;
        logic                              sop;
        logic                              eop;
    } commit_data_t;

    function automatic int pid_width(input int groups);
        return (groups > 1) ? $clog2(groups) : 1;
    endfunction

endpackage

// File: rtl/vx_commit_if.sv
// Commit packet channel: valid/ready handshake carrying commit_data_t.
// The sender drives the master side.
interface vx_commit_if;
    import vx_commit_sender_pkg::*;

    logic         valid;
    commit_data_t data;
    logic         ready;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/vx_commit_sender_elastic_buffer.sv
// Two-entry elastic buffer with registered outputs and registered ready.
// Head register feeds the output; tail register absorbs one beat of backpressure.
module vx_commit_sender_elastic_buffer #(
    parameter int DATAW = 8,
    parameter int SIZE  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [DATAW-1:0] data_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [DATAW-1:0] data_out
);

    if (SIZE != 2) begin : g_bad_size
        $error("elastic buffer supports SIZE=2 only");
    end

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_n;
    logic             rdy_r;
    logic [DATAW-1:0] head;
    logic [DATAW-1:0] tail;
    logic             in_fire;
    logic             out_fire;

    // Gating with reset keeps any stale beat from firing in the reset cycle.
    assign ready_in  = rdy_r && !reset;
    assign valid_out = (state != S_EMPTY) && !reset;
    assign data_out  = head;
    assign in_fire   = valid_in && ready_in;
    assign out_fire  = valid_out && ready_out;

    always_comb begin
        state_n = state;
        unique case (state)
            S_EMPTY: if (in_fire) state_n = S_ONE;
            S_ONE: begin
                if (in_fire && !out_fire)
                    state_n = S_FULL;
                else if (!in_fire && out_fire)
                    state_n = S_EMPTY;
            end
            S_FULL: if (out_fire) state_n = S_ONE;
            default: state_n = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_EMPTY;
            rdy_r <= 1'b1;
        end else begin
            state <= state_n;
            rdy_r <= (state_n != S_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if ((state == S_EMPTY && in_fire)
         || (state == S_ONE && in_fire && out_fire))
            head <= data_in;
        else if (state == S_FULL && out_fire)
            head <= tail;
        if (state == S_ONE && in_fire && !out_fire)
            tail <= data_in;
    end

endmodule

// File: rtl/vx_commit_sender.sv
// Expands lane-group result beats into full-width commit packets.
// Optional COMMIT_SENDER_STALL_CTR_EN adds the stall_cycles counter port.
module vx_commit_sender
    import vx_commit_sender_pkg::*;
#(
    parameter  int NUM_LANES     = NUM_THREADS,
    parameter  int OUT_BUF_DEPTH = 2,
    localparam int PID_W = pid_width(NUM_THREADS / NUM_LANES)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [UUID_WIDTH-1:0]      in_uuid,
    input  logic [NW_WIDTH-1:0]        in_wid,
    input  logic [PC_BITS-1:0]         in_PC,
    input  logic [NR_BITS-1:0]         in_rd,
    input  logic                       in_wb,
    input  logic [NUM_LANES-1:0]       in_tmask,
    input  logic [NUM_LANES*XLEN-1:0]  in_data,
    input  logic [PID_W-1:0]           in_pid,
    input  logic                       in_sop,
    input  logic                       in_eop,
    vx_commit_if.master                commit_if,
    output logic [NUM_WARPS-1:0]       pending_warps
`ifdef COMMIT_SENDER_STALL_CTR_EN
  , output logic [PERF_CTR_BITS-1:0]   stall_cycles
`endif
);

    if (NUM_THREADS % NUM_LANES != 0) begin : g_bad_lanes
        $error("NUM_LANES must divide NUM_THREADS");
    end

    logic [PID_W-1:0]            pid_eff;
    int                          lane_off;
    logic [NUM_THREADS-1:0]      tmask_exp;
    logic [NUM_THREADS*XLEN-1:0] data_exp;
    commit_data_t                pkt;
    logic                        in_fire;

    // A single lane group means there is nothing to select.
    assign pid_eff   = (NUM_LANES == NUM_THREADS) ? '0 : in_pid;
    assign lane_off  = int'(pid_eff) * NUM_LANES;
    assign tmask_exp = NUM_THREADS'(in_tmask) << lane_off;
    assign data_exp  = (NUM_THREADS*XLEN)'(in_data)
                       << (lane_off * XLEN);

    always_comb begin
        pkt       = '0;
        pkt.uuid  = in_uuid;
        pkt.wid   = in_wid;
        pkt.tmask = tmask_exp;
        pkt.PC    = in_PC;
        pkt.wb    = in_wb;
        pkt.rd    = in_rd;
        pkt.data  = data_exp;
        pkt.sop   = in_sop;
        pkt.eop   = in_eop;
    end

    assign in_fire = in_valid && in_ready;

    vx_commit_sender_elastic_buffer #(
        .DATAW ($bits(commit_data_t)),
        .SIZE  (OUT_BUF_DEPTH)
    ) out_buf (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (in_valid),
        .ready_in  (in_ready),
        .data_in   (pkt),
        .valid_out (commit_if.valid),
        .ready_out (commit_if.ready),
        .data_out  (commit_if.data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_warps <= '0;
        end else if (in_fire) begin
            if (in_eop)
                pending_warps[in_wid] <= 1'b0;
            else if (in_sop)
                pending_warps[in_wid] <= 1'b1;
        end
    end

    // A sop must open a closed warp; a continuation must hit an open one.
    a_sop_protocol: assert property (
        @(posedge clk) disable iff (reset)
        in_fire |-> (in_sop != pending_warps[in_wid])
    );

`ifdef COMMIT_SENDER_STALL_CTR_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles <= '0;
        else if (commit_if.valid && !commit_if.ready)
            stall_cycles <= stall_cycles + 1'b1;
    end
`endif

endmodule

// File: tb/tb_vx_commit_sender.sv
// Bench for vx_commit_sender with NUM_LANES=4 over 8 threads.
// Table vectors, handshake sequences and a scoreboard on the commit channel.
module tb_vx_commit_sender;
    import vx_commit_sender_pkg::*;

    localparam int L  = 4;
    localparam int PW = pid_width(NUM_THREADS / L);

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    logic [UUID_WIDTH-1:0]    in_uuid;
    logic [NW_WIDTH-1:0]      in_wid;
    logic [PC_BITS-1:0]       in_PC;
    logic [NR_BITS-1:0]       in_rd;
    logic                     in_wb;
    logic [L-1:0]             in_tmask;
    logic [L*XLEN-1:0]        in_data;
    logic [PW-1:0]            in_pid;
    logic                     in_sop;
    logic                     in_eop;
    logic [NUM_WARPS-1:0]     pending_warps;
    logic                     out_ready;
`ifdef COMMIT_SENDER_STALL_CTR_EN
    logic [PERF_CTR_BITS-1:0] stall_cycles;
`endif

    vx_commit_if cif ();
    assign cif.ready = out_ready;

    always #5 clk = ~clk;

    vx_commit_sender #(
        .NUM_LANES     (L),
        .OUT_BUF_DEPTH (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_uuid       (in_uuid),
        .in_wid        (in_wid),
        .in_PC         (in_PC),
        .in_rd         (in_rd),
        .in_wb         (in_wb),
        .in_tmask      (in_tmask),
        .in_data       (in_data),
        .in_pid        (in_pid),
        .in_sop        (in_sop),
        .in_eop        (in_eop),
        .commit_if     (cif),
        .pending_warps (pending_warps)
`ifdef COMMIT_SENDER_STALL_CTR_EN
      , .stall_cycles  (stall_cycles)
`endif
    );

    typedef struct {
        logic         pid;
        logic [3:0]   tm;
        logic [127:0] d;
        logic [7:0]   etm;
        logic [255:0] ed;
    } vec_t;

    vec_t         tbl [4];
    int           checks = 0;
    int           errors = 0;
    int           outs   = 0;
    commit_data_t exp_q [$];
    commit_data_t cur_exp;
    commit_data_t mon_e;

    task automatic chk(input string name,
                       input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Scoreboard: push on accepted input, pop on output fire.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (cif.valid && out_ready) begin
                outs++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_extra uuid %h want none",
                             cif.data.uuid);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (cif.data !== mon_e) begin
                        errors++;
                        $display("FAIL out_pkt uuid %h/%h tmask %b/%b data %h/%h",
                                 cif.data.uuid, mon_e.uuid,
                                 cif.data.tmask, mon_e.tmask,
                                 cif.data.data, mon_e.data);
                    end
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(cur_exp);
        end
    end

    function automatic logic [7:0] m_tm(input logic pid,
                                        input logic [3:0] tm);
        logic [7:0] r = '0;
        for (int i = 0; i < 4; i++)
            r[int'(pid)*4 + i] = tm[i];
        return r;
    endfunction

    function automatic logic [255:0] m_data(input logic pid,
                                            input logic [127:0] d);
        logic [255:0] r = '0;
        for (int i = 0; i < 4; i++)
            r[(int'(pid)*4 + i)*32 +: 32] = d[i*32 +: 32];
        return r;
    endfunction

    task automatic beat(input logic [1:0] wid,
                        input logic [UUID_WIDTH-1:0] uuid,
                        input logic pid,
                        input logic [3:0] tm,
                        input logic [127:0] d,
                        input logic sop,
                        input logic eop,
                        input logic [7:0] etm,
                        input logic [255:0] ed);
        in_valid  = 1'b1;
        in_wid    = wid;
        in_uuid   = uuid;
        in_PC     = PC_BITS'(uuid * 3);
        in_rd     = uuid[NR_BITS-1:0];
        in_wb     = uuid[0];
        in_pid    = pid;
        in_tmask  = tm;
        in_data   = d;
        in_sop    = sop;
        in_eop    = eop;
        cur_exp.uuid  = uuid;
        cur_exp.wid   = wid;
        cur_exp.tmask = etm;
        cur_exp.PC    = PC_BITS'(uuid * 3);
        cur_exp.wb    = uuid[0];
        cur_exp.rd    = uuid[NR_BITS-1:0];
        cur_exp.data  = ed;
        cur_exp.sop   = sop;
        cur_exp.eop   = eop;
    endtask

    // Call at a falling edge with a beat driven; returns at a falling edge.
    task automatic wait_accept();
        for (int k = 0; k < 20; k++) begin
            #3;
            if (in_ready) begin
                @(negedge clk);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("accept_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int o0;
        logic [3:0]   rtm;
        logic [127:0] rd;
        logic         rp;

        tbl[0] = '{1'b1, 4'b1011,
                   {32'd4, 32'd3, 32'd2, 32'd1},
                   8'b1011_0000,
                   {32'd4, 32'd3, 32'd2, 32'd1, 128'd0}};
        tbl[1] = '{1'b0, 4'b0110,
                   {32'd8, 32'd7, 32'd6, 32'd5},
                   8'b0000_0110,
                   {128'd0, 32'd8, 32'd7, 32'd6, 32'd5}};
        tbl[2] = '{1'b0, 4'b1111,
                   {32'h11, 32'h22, 32'h33, 32'h44},
                   8'b0000_1111,
                   {128'd0, 32'h11, 32'h22, 32'h33, 32'h44}};
        tbl[3] = '{1'b1, 4'b0000,
                   {32'ha, 32'hb, 32'hc, 32'hd},
                   8'b0000_0000,
                   {32'ha, 32'hb, 32'hc, 32'hd, 128'd0}};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_uuid   = '0;
        in_wid    = '0;
        in_PC     = '0;
        in_rd     = '0;
        in_wb     = 1'b0;
        in_tmask  = '0;
        in_data   = '0;
        in_pid    = '0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        out_ready = 1'b1;
        cur_exp   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #3;
        chk("rst_valid", 64'(cif.valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_pending", 64'(pending_warps), 64'd0);
`ifdef COMMIT_SENDER_STALL_CTR_EN
        chk("rst_stall", 64'(stall_cycles), 64'd0);
        out_ready = 1'b0;
        @(negedge clk);
        beat(2'd0, 44'd7, tbl[0].pid, tbl[0].tm, tbl[0].d,
             1'b1, 1'b1, tbl[0].etm, tbl[0].ed);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #3;
        chk("stall_5", 64'(stall_cycles), 64'd5);
        @(negedge clk);
        drain();
`endif

        // Table vectors, one beat then one idle cycle each.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            beat(2'(i), UUID_WIDTH'(i + 1), tbl[i].pid, tbl[i].tm,
                 tbl[i].d, 1'b1, 1'b1, tbl[i].etm, tbl[i].ed);
            @(negedge clk);
            in_valid = 1'b0;
            #3;
            chk("lat_valid", 64'(cif.valid), 64'd1);
        end
        @(negedge clk);
        #3;
        chk("lat_idle", 64'(cif.valid), 64'd0);

        // Backpressure: A and B fill the buffer, C waits.
        @(negedge clk);
        out_ready = 1'b0;
        beat(2'd0, 44'd100, 1'b0, 4'b0001, 128'h100,
             1'b1, 1'b1, 8'b0000_0001, 256'h100);
        @(negedge clk);
        beat(2'd1, 44'd101, 1'b1, 4'b0010, 128'h101,
             1'b1, 1'b1, 8'b0010_0000, m_data(1'b1, 128'h101));
        #3;
        chk("b_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        beat(2'd2, 44'd102, 1'b0, 4'b0100, 128'h102,
             1'b1, 1'b1, 8'b0000_0100, 256'h102);
        #3;
        chk("c_blocked", 64'(in_ready), 64'd0);
        chk("hold_valid", 64'(cif.valid), 64'd1);
        chk("hold_uuid", 64'(cif.data.uuid), 64'd100);
        @(negedge clk);
        #3;
        chk("hold_valid2", 64'(cif.valid), 64'd1);
        chk("hold_uuid2", 64'(cif.data.uuid), 64'd100);
        @(negedge clk);
        out_ready = 1'b1;
        wait_accept();
        drain();

        // Pending-warp tracking over a two-beat sequence.
        @(negedge clk);
        beat(2'd2, 44'd200, 1'b0, 4'b1111, 128'h200,
             1'b1, 1'b0, 8'b0000_1111, 256'h200);
        wait_accept();
        #3;
        chk("pend_open", 64'(pending_warps), 64'b0100);
        @(negedge clk);
        beat(2'd2, 44'd201, 1'b1, 4'b1111, 128'h201,
             1'b0, 1'b1, 8'b1111_0000, m_data(1'b1, 128'h201));
        wait_accept();
        #3;
        chk("pend_close", 64'(pending_warps), 64'b0000);
        @(negedge clk);
        drain();

        // Sixteen back-to-back beats at full rate.
        o0 = outs;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            rtm = 4'($urandom());
            rp  = 1'($urandom());
            rd  = {$urandom(), $urandom(), $urandom(), $urandom()};
            beat(2'($urandom()), UUID_WIDTH'(1000 + k), rp, rtm, rd,
                 1'b1, 1'b1, m_tm(rp, rtm), m_data(rp, rd));
            #3;
            chk("b2b_ready", 64'(in_ready), 64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        chk("b2b_queue", 64'(exp_q.size()), 64'd0);
        chk("b2b_count", 64'(outs - o0), 64'd16);
        @(negedge clk);
        drain();

        // Reset while full drops both buffered beats.
        @(negedge clk);
        out_ready = 1'b0;
        beat(2'd1, 44'd300, 1'b0, 4'b0011, 128'h300,
             1'b1, 1'b0, 8'b0000_0011, 256'h300);
        wait_accept();
        beat(2'd3, 44'd301, 1'b0, 4'b0011, 128'h301,
             1'b1, 1'b1, 8'b0000_0011, 256'h301);
        wait_accept();
        #3;
        chk("full_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #3;
        chk("rst2_valid", 64'(cif.valid), 64'd0);
        chk("rst2_ready", 64'(in_ready), 64'd1);
        chk("rst2_pending", 64'(pending_warps), 64'd0);
        o0 = outs;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #3;
        chk("no_stale", 64'(outs - o0), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
